// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter for a fetch requester and a data requester.
// One transaction is outstanding at a time. Data normally wins, but fetch is
// forced through after MAX_DSTREAK back-to-back data grants made while it waited.
// Every completion passes through a one-cycle ACK state so that a request line
// still high during its ack is not granted a second time.

module mem_port_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  // Fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  // Data requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  // Shared memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StAck
  } state_e;

  localparam logic [3:0] MaxStreak = 4'(MAX_DSTREAK);

  state_e      state_q, state_d;
  logic [3:0]  dstreak_q, dstreak_d;
  logic        win_d_q;      // 1 while the data requester owns the transaction
  logic        grant_i;
  logic        grant_d;
  logic        mem_done;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  // Arbitration: data first, unless fetch has been passed over MAX_DSTREAK times.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == StIdle) begin
      if (d_req && !(if_req && (dstreak_q == MaxStreak))) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // mem_ready only means something while a transaction is outstanding.
  always_comb begin
    mem_done = 1'b0;
    if ((state_q == StBusyI) || (state_q == StBusyD)) begin
      mem_done = mem_ready;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d = StBusyD;
        end else if (grant_i) begin
          state_d = StBusyI;
        end
      end
      StBusyI, StBusyD: begin
        if (mem_done) begin
          state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state: ack pulses and hazard stalls.
  always_comb begin
    if_ack   = 1'b0;
    d_ack    = 1'b0;
    if (state_q == StAck) begin
      if_ack = ~win_d_q;
      d_ack  = win_d_q;
    end
    if_stall = if_req & ~if_ack;
    d_stall  = d_req & ~d_ack;
  end

  // Starvation counter: counts data grants that made a waiting fetch wait longer.
  always_comb begin
    dstreak_d = dstreak_q;
    if (grant_i) begin
      dstreak_d = 4'd0;
    end else if (grant_d) begin
      if (!if_req) begin
        dstreak_d = 4'd0;
      end else if (dstreak_q != MaxStreak) begin
        dstreak_d = dstreak_q + 4'd1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dstreak_q <= 4'd0;
    end else begin
      dstreak_q <= dstreak_d;
    end
  end

  // Memory-port request and attributes: latched on grant, held until mem_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      win_d_q     <= 1'b0;
    end else begin
      if (grant_d) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= d_we;
        mem_addr_q  <= d_addr;
        mem_wdata_q <= d_wdata;
        win_d_q     <= 1'b1;
      end else if (grant_i) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= if_addr;
        mem_wdata_q <= 32'd0;
        win_d_q     <= 1'b0;
      end else if (mem_done) begin
        mem_req_q <= 1'b0;
      end
    end
  end

  // Read-data capture: only the winner's register, only for reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else if (mem_done && !mem_we_q) begin
      if (win_d_q) begin
        d_rdata_q <= mem_rdata;
      end else begin
        if_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table followed by
// hand-written starvation and asynchronous-reset sequences.

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MAX_DSTREAK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_stall  (if_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_stall   (d_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ifr;
    logic [31:0] ifa;
    logic        dr, dwe;
    logic [31:0] da, dwd;
    logic        mrdy;
    logic [31:0] mrd;
    logic        e_mreq, e_mwe;
    logic [31:0] e_maddr, e_mwd;
    logic        e_iack, e_dack;
    logic [31:0] e_ir, e_drd;
    logic        e_istall, e_dstall;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(
    input logic r, input logic ifr, input logic [31:0] ifa,
    input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
    input logic mrdy, input logic [31:0] mrd,
    input logic mreq, input logic mwe, input logic [31:0] maddr, input logic [31:0] mwd,
    input logic iack, input logic dack, input logic [31:0] ir, input logic [31:0] drd,
    input logic istall, input logic dstall);
    vec_t x;
    x.rst = r;         x.ifr = ifr;       x.ifa = ifa;
    x.dr = dr;         x.dwe = dwe;       x.da = da;        x.dwd = dwd;
    x.mrdy = mrdy;     x.mrd = mrd;
    x.e_mreq = mreq;   x.e_mwe = mwe;     x.e_maddr = maddr; x.e_mwd = mwd;
    x.e_iack = iack;   x.e_dack = dack;   x.e_ir = ir;      x.e_drd = drd;
    x.e_istall = istall; x.e_dstall = dstall;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  localparam logic [31:0] I1 = 32'h0050_0093;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] I2 = 32'h3333_3333;
  localparam logic [31:0] I3 = 32'h5555_5555;
  localparam logic [31:0] BEEF = 32'hDEAD_BEEF;

  logic [4:0] got;
  int         n;
  int         cnt;
  bit         seen;

  initial begin
    // rst ifr ifa   dr we da    dwd  rdy rdata        | req we addr  wdata ia da ir  drd is ds
    tv.push_back(v(1, 0, 0,     0, 0, 0,    0,    0, 0,            0, 0, 0,    0,    0, 0, 0,  0,  0, 0));
    tv.push_back(v(0, 0, 0,     0, 0, 0,    0,    0, 0,            0, 0, 0,    0,    0, 0, 0,  0,  0, 0));
    // Fetch only, 3-cycle memory
    tv.push_back(v(0, 1, 'h100, 0, 0, 0,    0,    0, 0,            0, 0, 0,    0,    0, 0, 0,  0,  1, 0));
    tv.push_back(v(0, 1, 'h100, 0, 0, 0,    0,    0, 0,            1, 0, 'h100, 0,   0, 0, 0,  0,  1, 0));
    tv.push_back(v(0, 1, 'h100, 0, 0, 0,    0,    0, 0,            1, 0, 'h100, 0,   0, 0, 0,  0,  1, 0));
    tv.push_back(v(0, 1, 'h100, 0, 0, 0,    0,    1, I1,           1, 0, 'h100, 0,   0, 0, 0,  0,  1, 0));
    tv.push_back(v(0, 1, 'h100, 0, 0, 0,    0,    0, 0,            0, 0, 'h100, 0,   1, 0, I1, 0,  0, 0));
    // mem_ready in IDLE is ignored
    tv.push_back(v(0, 0, 0,     0, 0, 0,    0,    1, 'hFFFF_FFFF,  0, 0, 'h100, 0,   0, 0, I1, 0,  0, 0));
    tv.push_back(v(0, 0, 0,     0, 0, 0,    0,    0, 0,            0, 0, 'h100, 0,   0, 0, I1, 0,  0, 0));
    // Simultaneous: data first, then fetch; mem_ready in ACK is ignored
    tv.push_back(v(0, 1, 'h200, 1, 0, 'h2000, 0,  0, 0,            0, 0, 'h100, 0,   0, 0, I1, 0,  1, 1));
    tv.push_back(v(0, 1, 'h200, 1, 0, 'h2000, 0,  1, D1,           1, 0, 'h2000, 0,  0, 0, I1, 0,  1, 1));
    tv.push_back(v(0, 1, 'h200, 1, 0, 'h2000, 0,  1, 'h2222_2222,  0, 0, 'h2000, 0,  0, 1, I1, D1, 1, 0));
    tv.push_back(v(0, 1, 'h200, 0, 0, 0,    0,    0, 0,            0, 0, 'h2000, 0,  0, 0, I1, D1, 1, 0));
    tv.push_back(v(0, 1, 'h200, 0, 0, 0,    0,    1, I2,           1, 0, 'h200, 0,   0, 0, I1, D1, 1, 0));
    tv.push_back(v(0, 1, 'h200, 0, 0, 0,    0,    0, 0,            0, 0, 'h200, 0,   1, 0, I2, D1, 0, 0));
    tv.push_back(v(0, 0, 0,     0, 0, 0,    0,    0, 0,            0, 0, 'h200, 0,   0, 0, I2, D1, 0, 0));
    // Store; fetch request arriving mid-transaction must not disturb it
    tv.push_back(v(0, 0, 0,     1, 1, 'h40, BEEF, 0, 0,            0, 0, 'h200, 0,   0, 0, I2, D1, 0, 1));
    tv.push_back(v(0, 1, 'h300, 1, 1, 'h40, BEEF, 0, 0,            1, 1, 'h40, BEEF, 0, 0, I2, D1, 1, 1));
    tv.push_back(v(0, 1, 'h300, 1, 1, 'h40, BEEF, 1, 'h4444_4444,  1, 1, 'h40, BEEF, 0, 0, I2, D1, 1, 1));
    tv.push_back(v(0, 1, 'h300, 1, 1, 'h40, BEEF, 0, 0,            0, 1, 'h40, BEEF, 0, 1, I2, D1, 1, 0));
    tv.push_back(v(0, 1, 'h300, 0, 0, 0,    0,    0, 0,            0, 1, 'h40, BEEF, 0, 0, I2, D1, 1, 0));
    tv.push_back(v(0, 1, 'h300, 0, 0, 0,    0,    1, I3,           1, 0, 'h300, 0,   0, 0, I2, D1, 1, 0));
    tv.push_back(v(0, 1, 'h300, 0, 0, 0,    0,    0, 0,            0, 0, 'h300, 0,   1, 0, I3, D1, 0, 0));
    tv.push_back(v(0, 0, 0,     0, 0, 0,    0,    0, 0,            0, 0, 'h300, 0,   0, 0, I3, D1, 0, 0));

    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk);
      #1;
      rst = tv[i].rst;   if_req = tv[i].ifr; if_addr = tv[i].ifa;
      d_req = tv[i].dr;  d_we = tv[i].dwe;   d_addr = tv[i].da;  d_wdata = tv[i].dwd;
      mem_ready = tv[i].mrdy; mem_rdata = tv[i].mrd;
      #3;
      chk($sformatf("row%0d mem_req", i),   32'(mem_req),   32'(tv[i].e_mreq));
      chk($sformatf("row%0d mem_we", i),    32'(mem_we),    32'(tv[i].e_mwe));
      chk($sformatf("row%0d mem_addr", i),  mem_addr,       tv[i].e_maddr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata,      tv[i].e_mwd);
      chk($sformatf("row%0d if_ack", i),    32'(if_ack),    32'(tv[i].e_iack));
      chk($sformatf("row%0d d_ack", i),     32'(d_ack),     32'(tv[i].e_dack));
      chk($sformatf("row%0d if_rdata", i),  if_rdata,       tv[i].e_ir);
      chk($sformatf("row%0d d_rdata", i),   d_rdata,        tv[i].e_drd);
      chk($sformatf("row%0d if_stall", i),  32'(if_stall),  32'(tv[i].e_istall));
      chk($sformatf("row%0d d_stall", i),   32'(d_stall),   32'(tv[i].e_dstall));
    end

    // Starvation: both requesters held high, single-cycle memory.
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1;  d_we = 1'b0; d_addr = 32'h2000;
    mem_ready = 1'b1; mem_rdata = 32'hAAAA_5555;
    got = '0;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(posedge clk);
      #3;
      if (d_ack) begin
        got[n] = 1'b0;
        n++;
      end else if (if_ack) begin
        got[n] = 1'b1;
        n++;
        if (n == 5) chk("starve dstreak after fetch grant", 32'(dut.dstreak_q), 32'd0);
      end
    end
    chk("starve grant count", n, 5);
    chk("starve grant order (1=fetch)", 32'(got), 32'b10000);
    @(posedge clk);
    #1;
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset while a load is outstanding.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    @(posedge clk);
    #2;
    chk("pre-reset mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    d_req = 1'b0;
    #1;
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset if_rdata", if_rdata, 32'd0);
    chk("reset d_rdata", d_rdata, 32'd0);
    chk("reset outputs or", 32'(mem_we | d_ack | if_ack | (|mem_wdata)), 32'd0);
    #1;
    rst = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h6666_6666;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #3;
      if (d_ack || mem_req) seen = 1'b1;
    end
    chk("post-reset no d_ack/mem_req", 32'(seen), 32'd0);
    chk("post-reset d_rdata", d_rdata, 32'd0);

    // The next fetch is served normally with minimum latency.
    #1;
    if_req = 1'b1; if_addr = 32'h400; mem_rdata = 32'h7777_7777;
    cnt = 0;
    seen = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(posedge clk);
      #3;
      if (if_ack) begin
        seen = 1'b1;
        cnt = c;
      end
    end
    chk("post-reset if_ack latency", cnt, 2);
    chk("post-reset if_rdata", if_rdata, 32'h7777_7777);
    chk("post-reset mem_addr", mem_addr, 32'h400);
    if_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
